// File: rtl/ip_timer_mc.sv
// Multi-channel APB timer: NUM_CH up/down counters with per-channel prescaler select,
// reload/compare registers, free-run/auto-reload/one-shot modes, W1C status and per-channel IRQ.
module ip_timer_mc #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic [3:0]            CLK_IN,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]           PWDATA,
  output logic [31:0]           PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic [NUM_CH-1:0]     IRQ
);

  localparam int unsigned CH_W = ADDR_WIDTH - 5;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [4:0] OFF_TCR  = 5'h00;
  localparam logic [4:0] OFF_TDR  = 5'h04;
  localparam logic [4:0] OFF_TCMP = 5'h08;
  localparam logic [4:0] OFF_TCNT = 5'h0C;
  localparam logic [4:0] OFF_TSR  = 5'h10;

  logic [7:0]           tcr_q  [NUM_CH];
  logic [7:0]           tcr_d  [NUM_CH];
  logic [CNT_WIDTH-1:0] tdr_q  [NUM_CH];
  logic [CNT_WIDTH-1:0] tdr_d  [NUM_CH];
  logic [CNT_WIDTH-1:0] tcmp_q [NUM_CH];
  logic [CNT_WIDTH-1:0] tcmp_d [NUM_CH];
  logic [CNT_WIDTH-1:0] tcnt_q [NUM_CH];
  logic [CNT_WIDTH-1:0] tcnt_d [NUM_CH];
  logic [2:0]           tsr_q  [NUM_CH];
  logic [2:0]           tsr_d  [NUM_CH];
  logic [3:0]           clk_in_q, clk_in_d;

  logic [NUM_CH-1:0]    sel_c, tick_c, wrap_c;
  logic [2:0]           set_c  [NUM_CH];

  logic [CH_W-1:0]      ch_idx;
  logic [4:0]           off;
  logic                 access_c, ch_ok_c, off_ok_c, err_c, wr_ok_c;
  logic                 unused_pwdata;

  assign ch_idx   = PADDR[ADDR_WIDTH-1:5];
  assign off      = PADDR[4:0];
  assign access_c = PSEL & PENABLE;
  assign ch_ok_c  = (32'(ch_idx) < NUM_CH);
  assign off_ok_c = (off == OFF_TCR) || (off == OFF_TDR) || (off == OFF_TCMP) ||
                    (off == OFF_TCNT) || (off == OFF_TSR);
  assign err_c    = !ch_ok_c || !off_ok_c || (PWRITE && (off == OFF_TCNT));
  assign wr_ok_c  = access_c & PWRITE & ~err_c;

  assign PREADY        = 1'b1;
  assign PSLVERR       = access_c & err_c;
  assign unused_pwdata = ^PWDATA;

  // Read mux: zero-extended, only during a valid read access phase
  always_comb begin
    PRDATA = '0;
    if (access_c && !PWRITE && !err_c) begin
      for (int ch = 0; ch < int'(NUM_CH); ch++) begin
        if (ch_idx == CH_W'(ch)) begin
          case (off)
            OFF_TCR:  PRDATA = 32'(tcr_q[ch]);
            OFF_TDR:  PRDATA = 32'(tdr_q[ch]);
            OFF_TCMP: PRDATA = 32'(tcmp_q[ch]);
            OFF_TCNT: PRDATA = 32'(tcnt_q[ch]);
            OFF_TSR:  PRDATA = 32'(tsr_q[ch]);
            default:  PRDATA = '0;
          endcase
        end
      end
    end
  end

  always_comb begin
    for (int ch = 0; ch < int'(NUM_CH); ch++) begin
      IRQ[ch] = tcr_q[ch][7] & (|tsr_q[ch]);
    end
  end

  // Per-channel next state: LOAD > tick-driven count > hold, then APB register writes
  always_comb begin
    clk_in_d = CLK_IN;
    for (int ch = 0; ch < int'(NUM_CH); ch++) begin
      tcr_d[ch]  = tcr_q[ch];
      tdr_d[ch]  = tdr_q[ch];
      tcmp_d[ch] = tcmp_q[ch];
      tcnt_d[ch] = tcnt_q[ch];
      set_c[ch]  = 3'b000;
      wrap_c[ch] = 1'b0;
      sel_c[ch]  = wr_ok_c && (ch_idx == CH_W'(ch));
      tick_c[ch] = CLK_IN[tcr_q[ch][3:2]] & ~clk_in_q[tcr_q[ch][3:2]];

      if (sel_c[ch] && (off == OFF_TCR) && PWDATA[6]) begin
        tcnt_d[ch] = tdr_q[ch];
      end else if (tick_c[ch] && tcr_q[ch][0]) begin
        if (!tcr_q[ch][1]) begin
          if (tcnt_q[ch] == CNT_MAX) begin
            set_c[ch][0] = 1'b1;
            wrap_c[ch]   = 1'b1;
            tcnt_d[ch]   = (tcr_q[ch][5:4] == 2'b01) ? tdr_q[ch] : '0;
          end else begin
            tcnt_d[ch] = tcnt_q[ch] + CNT_WIDTH'(1);
          end
        end else begin
          if (tcnt_q[ch] == '0) begin
            set_c[ch][1] = 1'b1;
            wrap_c[ch]   = 1'b1;
            tcnt_d[ch]   = (tcr_q[ch][5:4] == 2'b01) ? tdr_q[ch] : CNT_MAX;
          end else begin
            tcnt_d[ch] = tcnt_q[ch] - CNT_WIDTH'(1);
          end
        end
        if (tcnt_d[ch] == tcmp_q[ch]) set_c[ch][2] = 1'b1;
        if (wrap_c[ch] && (tcr_q[ch][5:4] == 2'b10)) tcr_d[ch][0] = 1'b0;
      end

      tsr_d[ch] = tsr_q[ch];
      if (sel_c[ch]) begin
        case (off)
          OFF_TCR:  tcr_d[ch]  = {PWDATA[7], 1'b0, PWDATA[5:0]};
          OFF_TDR:  tdr_d[ch]  = PWDATA[CNT_WIDTH-1:0];
          OFF_TCMP: tcmp_d[ch] = PWDATA[CNT_WIDTH-1:0];
          OFF_TSR:  tsr_d[ch]  = tsr_q[ch] & ~PWDATA[2:0];
          default:  ;
        endcase
      end
      // Hardware set overrides a same-cycle W1C
      tsr_d[ch] = tsr_d[ch] | set_c[ch];
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      clk_in_q <= '0;
      for (int ch = 0; ch < int'(NUM_CH); ch++) begin
        tcr_q[ch]  <= '0;
        tdr_q[ch]  <= '0;
        tcmp_q[ch] <= '0;
        tcnt_q[ch] <= '0;
        tsr_q[ch]  <= '0;
      end
    end else begin
      clk_in_q <= clk_in_d;
      for (int ch = 0; ch < int'(NUM_CH); ch++) begin
        tcr_q[ch]  <= tcr_d[ch];
        tdr_q[ch]  <= tdr_d[ch];
        tcmp_q[ch] <= tcmp_d[ch];
        tcnt_q[ch] <= tcnt_d[ch];
        tsr_q[ch]  <= tsr_d[ch];
      end
    end
  end

endmodule
